// File: rtl/cs_accumulator_if.sv
// Handshake bundle for cs_accumulator: sample stream in, resolved packet total out.
// The master drives samples and accepts results; the slave is the accumulator.
interface cs_accumulator_if #(
    parameter int width       = 8,
    parameter int acc_width   = 12,
    parameter int count_width = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [width-1:0]       in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [acc_width-1:0]   sum;
    logic [count_width-1:0] count;
    logic                   carry_out;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, sum, count, carry_out
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, sum, count, carry_out
    );
endinterface

// File: rtl/cs_accumulator.sv
// Streaming packet accumulator: carry-save running total per beat, then a
// chunk-per-cycle ripple resolve of S + C before presenting the result.
module cs_accumulator #(
    parameter int width       = 8,
    parameter int acc_width   = 12,
    parameter int chunk       = 4,
    parameter int count_width = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cs_accumulator_if.slave     bus
);
    localparam int n_slices  = acc_width / chunk;
    localparam int idx_width = (n_slices > 1) ? $clog2(n_slices) : 1;

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

    state_t                 state;
    logic [acc_width-1:0]   s_vec;
    logic [acc_width-1:0]   c_vec;
    logic [acc_width-1:0]   x_vec;
    logic [acc_width-1:0]   maj_vec;
    logic [acc_width-1:0]   sum_q;
    logic [count_width-1:0] beat_count;
    logic [count_width-1:0] count_q;
    logic [idx_width-1:0]   slice_idx;
    logic [chunk-1:0]       s_slice;
    logic [chunk-1:0]       c_slice;
    logic [chunk:0]         slice_total;
    logic                   wrap;
    logic                   cy;
    logic                   carry_q;
    logic                   accept;

    assign accept        = bus.in_valid && (state == ACCUM);
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == OUTPUT);
    assign bus.sum       = sum_q;
    assign bus.count     = count_q;
    assign bus.carry_out = carry_q;

    always_comb begin
        x_vec              = '0;
        x_vec[width-1:0]   = bus.in_data;
        maj_vec            = (s_vec & c_vec) | (s_vec & x_vec) | (c_vec & x_vec);
    end

    // Slice mux by loop so the select never reaches past the top of S/C.
    always_comb begin
        s_slice = '0;
        c_slice = '0;
        for (int k = 0; k < n_slices; k++) begin
            if (slice_idx == idx_width'(k)) begin
                s_slice = s_vec[k*chunk +: chunk];
                c_slice = c_vec[k*chunk +: chunk];
            end
        end
        slice_total = {1'b0, s_slice} + {1'b0, c_slice} + {{chunk{1'b0}}, cy};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            s_vec      <= '0;
            c_vec      <= '0;
            sum_q      <= '0;
            beat_count <= '0;
            count_q    <= '0;
            slice_idx  <= '0;
            wrap       <= 1'b0;
            cy         <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s_vec <= s_vec ^ c_vec ^ x_vec;
                        c_vec <= maj_vec << 1;
                        // The carry leaving C's top bit is a lost 2^acc_width.
                        wrap  <= wrap | maj_vec[acc_width-1];
                        if (beat_count != '1) begin
                            beat_count <= beat_count + 1'b1;
                        end
                        if (bus.in_last) begin
                            state     <= RESOLVE;
                            slice_idx <= '0;
                            cy        <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    if (slice_idx == '0) begin
                        count_q <= beat_count;
                    end
                    for (int k = 0; k < n_slices; k++) begin
                        if (slice_idx == idx_width'(k)) begin
                            sum_q[k*chunk +: chunk] <= slice_total[chunk-1:0];
                        end
                    end
                    cy <= slice_total[chunk];
                    if (slice_idx == idx_width'(n_slices - 1)) begin
                        carry_q <= wrap | slice_total[chunk];
                        state   <= OUTPUT;
                    end else begin
                        slice_idx <= slice_idx + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        s_vec      <= '0;
                        c_vec      <= '0;
                        beat_count <= '0;
                        wrap       <= 1'b0;
                        state      <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
